// File: rtl/freq_meter_pkg.sv
// freq_meter_pkg
//   Shared constants for the frequency meter: FSM state encodings and the
//   default gate length (one second of a 50 MHz system clock). The gate
//   constant is the same value the clock divider uses for its 1 Hz tick.
package freq_meter_pkg;

  localparam logic [0:0] ST_IDLE    = 1'b0;
  localparam logic [0:0] ST_MEASURE = 1'b1;

  localparam int unsigned GATE_1S_50MHZ = 32'd50_000_000;

endpackage

// File: rtl/sync_edge.sv
// sync_edge
//   Two-flop synchronizer followed by a history flop, producing a one-cycle
//   rise pulse for an asynchronous input. Reusable for buttons and other
//   async inputs. All flops clear to 0 on clr.
// Ports:
//   clk  - system clock
//   clr  - synchronous active-high reset
//   din  - asynchronous input
//   rise - high for one cycle when the synchronized input goes 0 -> 1
module sync_edge (
  input  logic clk,
  input  logic clr,
  input  logic din,
  output logic rise
);

  logic s1;
  logic s2;
  logic s3;

  always_ff @(posedge clk) begin
    if (clr) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= din;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign rise = s2 & ~s3;

endmodule

// File: rtl/freq_meter.sv
// freq_meter
//   Counts rising edges of sig_in over a gate window of GATE_CYCLES clocks and
//   publishes the result with a one-cycle valid strobe. Single-shot on start,
//   or back-to-back windows while cont is held high.
// Ports:
//   clk    - system clock
//   clr    - synchronous active-high reset, overrides everything
//   start  - level request to open a window (ignored while busy)
//   cont   - continuous mode, sampled at each window end
//   sig_in - asynchronous signal under test
//   busy   - window open
//   count  - edges counted in the last completed window (held)
//   valid  - one-cycle pulse when count/ovf update
//   ovf    - edge counter saturated in the window that produced count
//
//   state      | meaning
//   -----------+---------------------------------------------
//   ST_IDLE    | no window open, waiting for start
//   ST_MEASURE | gate window open, counting synchronized rises
module freq_meter
  import freq_meter_pkg::*;
#(
  parameter int unsigned GATE_CYCLES = GATE_1S_50MHZ,
  parameter int unsigned CNT_W       = 32
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             start,
  input  logic             cont,
  input  logic             sig_in,
  output logic             busy,
  output logic [CNT_W-1:0] count,
  output logic             valid,
  output logic             ovf
);

  localparam int unsigned GW = $clog2(GATE_CYCLES);
  localparam logic [GW-1:0] GATE_LAST = GW'(GATE_CYCLES - 1);

  logic [0:0]       state;
  logic [GW-1:0]    gate_cnt;
  logic [CNT_W-1:0] edge_cnt;
  logic [CNT_W-1:0] edge_nxt;
  logic             sat;
  logic             sat_nxt;
  logic             rise;
  logic             win_end;

  // Final window result, staged one cycle so the window-end cycle's own
  // edge is included before count/valid are presented.
  logic [CNT_W-1:0] fin_cnt;
  logic             fin_sat;
  logic             fin_pend;

  sync_edge u_sync (
    .clk  (clk),
    .clr  (clr),
    .din  (sig_in),
    .rise (rise)
  );

  // Saturating increment: at all-ones the counter holds and sat latches.
  always_comb begin
    edge_nxt = edge_cnt;
    sat_nxt  = sat;
    if (rise) begin
      if (&edge_cnt) begin
        sat_nxt = 1'b1;
      end else begin
        edge_nxt = edge_cnt + CNT_W'(1);
      end
    end
  end

  assign win_end = (state == ST_MEASURE) && (gate_cnt == GATE_LAST);
  assign busy    = (state == ST_MEASURE);

  always_ff @(posedge clk) begin
    if (clr) begin
      state    <= ST_IDLE;
      gate_cnt <= '0;
      edge_cnt <= '0;
      sat      <= 1'b0;
      fin_cnt  <= '0;
      fin_sat  <= 1'b0;
      fin_pend <= 1'b0;
      count    <= '0;
      ovf      <= 1'b0;
      valid    <= 1'b0;
    end else begin
      fin_pend <= 1'b0;
      valid    <= fin_pend;
      if (fin_pend) begin
        count <= fin_cnt;
        ovf   <= fin_sat;
      end

      case (state)
        ST_IDLE: begin
          if (start) begin
            state    <= ST_MEASURE;
            gate_cnt <= '0;
            edge_cnt <= '0;
            sat      <= 1'b0;
          end
        end
        ST_MEASURE: begin
          if (win_end) begin
            fin_cnt  <= edge_nxt;
            fin_sat  <= sat_nxt;
            fin_pend <= 1'b1;
            // Restart immediately so continuous windows abut with no gap.
            gate_cnt <= '0;
            edge_cnt <= '0;
            sat      <= 1'b0;
            if (!cont) begin
              state <= ST_IDLE;
            end
          end else begin
            gate_cnt <= gate_cnt + GW'(1);
            edge_cnt <= edge_nxt;
            sat      <= sat_nxt;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_freq_meter.sv
module tb_freq_meter;

  typedef struct {
    longint cnt;
    longint ovf;
    longint cyc;
    bit     chk;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

  // DUT A: GATE_CYCLES=100, CNT_W=32
  logic        clrA = 1'b1, startA = 1'b0, contA = 1'b0, sigA = 1'b0;
  logic        busyA, validA, ovfA;
  logic [31:0] countA;
  // DUT B: GATE_CYCLES=100, CNT_W=4
  logic        clrB = 1'b1, startB = 1'b0, contB = 1'b0, sigB = 1'b0;
  logic        busyB, validB, ovfB;
  logic [3:0]  countB;

  freq_meter #(.GATE_CYCLES(100), .CNT_W(32)) dut_a (
    .clk(clk), .clr(clrA), .start(startA), .cont(contA), .sig_in(sigA),
    .busy(busyA), .count(countA), .valid(validA), .ovf(ovfA));

  freq_meter #(.GATE_CYCLES(100), .CNT_W(4)) dut_b (
    .clk(clk), .clr(clrB), .start(startB), .cont(contB), .sig_in(sigB),
    .busy(busyB), .count(countB), .valid(validB), .ovf(ovfB));

  exp_t   sbA[$];
  exp_t   sbB[$];
  longint obsA[$];

  task automatic check(input string name, input longint act, input longint exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d required %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  // A-side stimulus generator: mode 0 = low, 1 = high, 2 = toggle every hp cycles
  int modeA = 0;
  int hpA   = 5;
  bit fastB = 1'b0;
  initial begin
    int ph;
    ph = 0;
    forever begin
      @(negedge clk);
      if (modeA == 0) sigA = 1'b0;
      else if (modeA == 1) sigA = 1'b1;
      else begin
        if (ph >= hpA - 1) begin
          ph = 0;
          sigA = ~sigA;
        end else ph++;
      end
      sigB = fastB ? ~sigB : 1'b0;
    end
  end

  // Monitors: pop an expectation whenever a DUT strobes valid.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (validA) begin
        if (sbA.size() == 0) begin
          total++; bad++;
          $display("FAIL a_unexpected_valid: got valid at cycle %0d, required none", cyc);
        end else begin
          e = sbA.pop_front();
          check("a_valid_cycle", cyc, e.cyc);
          if (e.chk) check("a_count", countA, e.cnt);
          else obsA.push_back(countA);
          check("a_ovf", ovfA, e.ovf);
        end
      end
    end
  end

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (validB) begin
        if (sbB.size() == 0) begin
          total++; bad++;
          $display("FAIL b_unexpected_valid: got valid at cycle %0d, required none", cyc);
        end else begin
          e = sbB.pop_front();
          check("b_valid_cycle", cyc, e.cyc);
          check("b_count", countB, e.cnt);
          check("b_ovf", ovfB, e.ovf);
        end
      end
    end
  end

  task automatic push_a(input longint c, input longint o, input longint t, input bit chk);
    exp_t e;
    e.cnt = c; e.ovf = o; e.cyc = t; e.chk = chk;
    sbA.push_back(e);
  endtask

  task automatic push_b(input longint c, input longint o, input longint t);
    exp_t e;
    e.cnt = c; e.ovf = o; e.cyc = t; e.chk = 1'b1;
    sbB.push_back(e);
  endtask

  // Pulse start for one cycle; returns the negedge cycle K before the sampling edge.
  task automatic pulse_a(output int k);
    k = cyc;
    startA = 1'b1;
    tick(1);
    startA = 1'b0;
  endtask

  task automatic pulse_b(output int k);
    k = cyc;
    startB = 1'b1;
    tick(1);
    startB = 1'b0;
  endtask

  initial begin
    int k;
    int nb;
    tick(3);
    check("a_rst_busy", busyA, 0);
    check("a_rst_count", countA, 0);
    check("a_rst_valid", validA, 0);
    check("a_rst_ovf", ovfA, 0);
    check("b_rst_busy", busyB, 0);
    check("b_rst_count", countB, 0);
    clrA = 1'b0;
    clrB = 1'b0;
    tick(5);

    // Basic count: period 10, single window
    modeA = 2; hpA = 5;
    tick(10);
    pulse_a(k);
    push_a(10, 0, k + 102, 1'b1);
    nb = 0;
    for (int i = 0; i < 110; i++) begin
      if (busyA) nb++;
      tick(1);
    end
    check("a_busy_cycles", nb, 100);
    tick(5);

    // Static low
    modeA = 0;
    tick(10);
    pulse_a(k);
    push_a(0, 0, k + 102, 1'b1);
    tick(115);

    // Static high from before clr release
    modeA = 1;
    tick(3);
    clrA = 1'b1;
    tick(2);
    clrA = 1'b0;
    tick(10);
    pulse_a(k);
    push_a(0, 0, k + 102, 1'b1);
    tick(115);

    // Start while busy: re-pulse at gate_cnt == 30
    modeA = 2; hpA = 5;
    tick(10);
    pulse_a(k);
    push_a(10, 0, k + 102, 1'b1);
    tick(30);
    startA = 1'b1;
    tick(1);
    startA = 1'b0;
    tick(85);

    // Reset mid-window at gate_cnt == 50
    pulse_a(k);
    tick(50);
    clrA = 1'b1;
    tick(1);
    clrA = 1'b0;
    check("a_midclr_busy", busyA, 0);
    check("a_midclr_count", countA, 0);
    check("a_midclr_ovf", ovfA, 0);
    check("a_midclr_valid", validA, 0);
    tick(120);
    pulse_a(k);
    push_a(10, 0, k + 102, 1'b1);
    tick(115);

    // Continuous mode, period 8: four abutting windows
    hpA = 4;
    tick(10);
    contA = 1'b1;
    pulse_a(k);
    for (int w = 1; w <= 4; w++) push_a(0, 0, k + 2 + 100 * w, 1'b0);
    tick(349);
    contA = 1'b0;
    tick(70);
    check("a_cont_windows", obsA.size(), 4);
    if (obsA.size() == 4) begin
      check("a_cont_pair01", obsA[0] + obsA[1], 25);
      check("a_cont_pair12", obsA[1] + obsA[2], 25);
      check("a_cont_pair23", obsA[2] + obsA[3], 25);
    end
    check("a_cont_idle_busy", busyA, 0);

    // Saturation on the 4-bit counter, then an edge-free window
    fastB = 1'b1;
    tick(10);
    pulse_b(k);
    push_b(15, 1, k + 102);
    tick(115);
    fastB = 1'b0;
    tick(10);
    pulse_b(k);
    push_b(0, 0, k + 102);
    tick(115);

    tick(20);
    check("a_sb_drained", sbA.size(), 0);
    check("b_sb_drained", sbB.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/freq_meter.md
# freq_meter

Measures the frequency of an external or internally generated digital signal. It counts rising edges of `sig_in` over a gate window of exactly `GATE_CYCLES` clock cycles, then presents the result with a one-cycle `valid` strobe. It is the measuring counterpart of the clock divider: it recovers an edge rate from a signal instead of producing one. It sits on the system clock and feeds display and readback logic.

## Interface

- `GATE_CYCLES`, default 50000000: gate window length in `clk` cycles, which is 1 s at 50 MHz. Legal range is ≥ 2.
- `CNT_W`, default 32: width of the edge counter and of `count`.

- `clk`  in  1: system clock. All logic is on the rising edge.
- `clr`  in  1: reset, synchronous and active-high.
- `start`  in  1: level-sampled request to begin one measurement. Ignored while `busy`.
- `cont`  in  1: continuous mode. Sampled at the end of each window.
- `sig_in`  in  1: signal under test. It is asynchronous to `clk`.
- `busy`  out  1: high while a gate window is open.
- `count`  out  `CNT_W`: rising edges counted in the last completed window. Held until the next window completes.
- `valid`  out  1: one-cycle pulse when `count` updates.
- `ovf`  out  1: high when the edge counter saturated during the window that produced `count`. Updated together with `count`.

## Operation

- **Input path:** `sig_in` passes through a 2-flop synchronizer, `s1` then `s2`, followed by a history register `s3`.
  - A rising edge is defined as `s2 & ~s3`.
  - The synchronizer and history registers reset to 0.
- **States:** IDLE and MEASURE.
- **IDLE:**
  - `busy`=0.
  - If `start`=1, go to MEASURE, clear `gate_cnt` and `edge_cnt` to 0, and set `busy`=1 on the next cycle.
- **MEASURE:**
  - Every cycle, increment `gate_cnt`.
  - A rising edge increments `edge_cnt`.
  - If `edge_cnt` equals all-ones, it holds its value and sets a sticky `sat` flag instead of wrapping.
- **Window end:** the cycle where `gate_cnt == GATE_CYCLES-1`.
  - That cycle's edge is included in the result.
  - On the next edge, `count` and `ovf` are loaded with the final values and `valid`=1.
  - If `cont`=1: stay in MEASURE. `gate_cnt`, `edge_cnt` and `sat` restart at 0 with no dead cycle, so no edge is lost or double-counted across windows.
  - If `cont`=0: go to IDLE with `busy`=0.
- **Starting early:** `start` asserted during MEASURE has no effect.
- **Widths:** `gate_cnt` is $clog2(GATE_CYCLES) bits. All comparisons are unsigned.

## Timing

- **Reset values:** all of the following are 0 one cycle after `clr` is sampled high:
  - outputs `busy`, `count`, `valid`, `ovf`;
  - internal `state`, `gate_cnt`, `edge_cnt`, `sat`, `s1`, `s2`, `s3`.
- **Reset priority:** `clr` overrides everything.
  - An assertion mid-window aborts the window.
  - No `valid` pulse is produced, and `count` is cleared.
- **Start timing:** `start` is sampled at edge N. MEASURE covers edges N+1 through N+`GATE_CYCLES`. `valid` is high during the cycle after edge N+`GATE_CYCLES`+1.
- **Edge latency:** a `sig_in` rise is visible as an edge 3 cycles after it is sampled by `s1`.
  - Windows are therefore defined on the synchronized signal.
  - Edges within the last 3 cycles before `start` or before the window closes fall into whichever window sees them at `s2`/`s3`.
- **Input-rate limit:** the maximum countable rate is `clk`/2, meaning `sig_in` high for ≥1 cycle and low for ≥1 cycle. Faster input aliases, and the result is undefined.
- **Continuous mode:** `valid` pulses exactly `GATE_CYCLES` cycles apart.
- **Simultaneous `clr` and `start`:** `clr` wins and the block stays in IDLE.

## Structure

- Package `freq_meter_pkg` holds:
  - the state encodings `ST_IDLE`=0 and `ST_MEASURE`=1;
  - the default `GATE_CYCLES` constant `GATE_1S_50MHZ`, shared with the divider's constants.
- Sub-module `sync_edge` contains the 2-flop synchronizer, the history flop and the rise output.
  - It has `clk`/`clr` reset-to-0 behaviour.
  - It can be reused for buttons and other async inputs.
- The top level holds the state machine, `gate_cnt`, the saturating `edge_cnt` and the output registers.

## Test plan

All scenarios use `GATE_CYCLES`=100 and `CNT_W`=32 unless stated.

- **Basic count:** `sig_in` toggles every 5 cycles (period 10), single `start` pulse. Expect `valid` exactly once, 101 cycles after the `start` sample, with `count`=10, `ovf`=0, and `busy` high for 100 cycles.
- **Static input:**
  - `sig_in` held at 0 for the whole run: expect `count`=0.
  - `sig_in` held at 1 from before `clr` release: expect `count`=0.
- **Saturation:** `CNT_W`=4 and `sig_in` toggles every cycle, giving 50 edges. Expect `count`=15 and `ovf`=1. The next window with no edges gives `count`=0 and `ovf`=0.
- **Reset mid-window:** `clr` pulsed at `gate_cnt`=50. Expect `busy`=0, `count`=0 and `ovf`=0 the next cycle, no `valid`, and a clean restart on the next `start`.
- **Continuous mode:** `cont`=1 with a period-8 input. Expect `valid` pulses 100 cycles apart, and each pair of adjacent windows sums to the total edges applied over those 200 cycles.
- **Start while busy:** `start` re-pulsed at `gate_cnt`=30. Expect no restart and a single `valid` at the original time.
